sobel_window_gen: RTL
=====================

# sobel_window_gen

Streaming 3x3 window generator that turns a raster-order grayscale pixel stream into the nine neighbourhood taps p0..p8 consumed by the `sobel` kernel. It replaces the file-driven window stimulus with hardware:
- buffers two image lines;
- zero-pads the image border;
- emits exactly one window per input pixel, centred on that pixel;
- flushes the final row and column itself at end of frame.

It sits between the pixel source and `sobel` (and its AxC variants).

## Interface
- IMG_W, 512: pixels per line (>=3)
- IMG_H, 512: lines per frame (>=2)
- PIX_W, 8: pixel width in bits
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input pixel present
- in_pix  in  PIX_W  input pixel, raster order, row 0 col 0 first
- in_ready  out  1  block accepts in_pix this cycle; transfer = in_valid & in_ready
- out_valid  out  1  window taps valid (one-cycle pulse per window, no backpressure)
- p0..p8  out  PIX_W each  window taps: p0 p1 p2 = row above (left, centre, right), p3 p4 p5 = centre row, p6 p7 p8 = row below
- out_sof  out  1  with out_valid: window centre is (0,0)
- out_eof  out  1  with out_valid: window centre is (IMG_H-1, IMG_W-1)

## Operation
- Accepted-pixel index k = row*IMG_W + col runs 0..IMG_W*IMG_H-1 per frame; (row, col) counters wrap at IMG_W and IMG_H.
- Window datapath:
  - 3x3 register array shifts one column left per advance.
  - The new right column is {line buffer 2[col], line buffer 1[col], in_pix}.
  - Each line buffer is read-before-write at col: line buffer 1 then holds in_pix, and line buffer 2 holds the old line buffer 1 value.
- Centre lags the newest pixel by IMG_W+1, so the window centred on k is formed when pixel k+IMG_W+1 is accepted.
- Border masking is applied at the output register from the centre coordinates (cr, cc); all masked taps are forced to 0:
  - cr==0 zeroes p0 p1 p2.
  - cr==IMG_H-1 zeroes p6 p7 p8.
  - cc==0 zeroes p0 p3 p6.
  - cc==IMG_W-1 zeroes p2 p5 p8. This also covers the row wrap, where the right column holds the next line's col 0.
- FSM states:
  - FILL: in_ready=1, no output. Counts the first IMG_W+1 accepted pixels. After accepting k==IMG_W, go to RUN.
  - RUN: in_ready=1. Every accepted pixel advances the window and emits one window. After accepting k==IMG_W*IMG_H-1, go to FLUSH.
  - FLUSH: in_ready=0. Advances with in_pix replaced by 0 for exactly IMG_W+1 cycles (flush counter 0..IMG_W) and emits one window per cycle. At flush count IMG_W, go to FILL and reset the frame counters.
- Output is exactly IMG_W*IMG_H windows per frame, in raster order of centre.
- in_valid=0 in FILL or RUN: nothing advances, out_valid=0 next cycle, and state is held.
- Back-to-back frames: the first pixel of the next frame is accepted on the cycle after FLUSH exits.
- Line buffers are never cleared; stale contents are always masked or overwritten before use.

## Timing
- Reset values:
  - state=FILL, all counters 0, in_ready=1;
  - out_valid=0, out_sof=0, out_eof=0;
  - p0..p8=0.
- Reset mid-frame: the next cycle is FILL with counters 0. A partial window is never emitted, and the pixels already received are discarded.
- Latency: window registered one cycle after the accepting (or flush) edge that completes it. out_valid is high for one cycle per window.
- Throughput: one pixel per cycle in FILL/RUN.
- Per frame, in_ready is low for exactly IMG_W+1 consecutive cycles.
- Arithmetic: no arithmetic on pixel data; taps are pure copies or 0.
- Counter widths are $clog2 of their range, with wrap compares on exact terminal values.

## Structure
- Package `sobel_pkg`:
  - PIX_W default;
  - default IMG_W/IMG_H;
  - FSM state enum {FILL, RUN, FLUSH}.
- Sub-module `sobel_line_buf`:
  - depth IMG_W, width PIX_W;
  - one read-before-write port: addr, wr_en, wdata, rdata;
  - instantiated twice.

## Test plan
Unless noted, use IMG_W=4, IMG_H=3, pixels 1..12 streamed with in_valid=1 continuously.
- Reset then frame: first out_valid occurs one cycle after accepting value 6, with out_sof=1 and p0..p8 = 0,0,0,0,1,2,0,5,6.
- Interior window: centre (1,1) gives 1,2,3,5,6,7,9,10,11. Row-wrap window, centre (1,3): 3,4,0,7,8,0,11,12,0.
- Flush: after value 12, in_ready=0 for exactly 5 cycles. The last window has out_eof=1 and taps 7,8,0,11,12,0,0,0,0. The total out_valid count is 12.
- Random in_valid gaps (~50%): the window sequence is identical to the gapless run, and out_valid never pulses on a cycle following an idle cycle.
- Two back-to-back frames, second frame 101..112: first window of frame 2 is 0,0,0,0,101,102,0,105,106, with no frame-1 data leaking into it.
- Assert rst after 7 pixels: outputs return to their reset values. A fresh frame afterwards matches the first scenario exactly.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel window generator.
//   DEF_PIX_W / DEF_IMG_W / DEF_IMG_H : default pixel width and frame size
//   state_e                           : window generator control states
package sobel_pkg;

    localparam int unsigned DEF_PIX_W = 8;
    localparam int unsigned DEF_IMG_W = 512;
    localparam int unsigned DEF_IMG_H = 512;

    // FILL: priming the line buffers, RUN: one window per pixel,
    // FLUSH: self-driven drain of the last row and column.
    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out bus of the Sobel window generator.
//   in_valid, in_pix, in_ready : raster pixel stream (valid/ready)
//   out_valid, out_sof, out_eof: one-cycle window strobe and frame markers
//   p0..p8                     : 3x3 taps, row-major, row above first
interface sobel_window_gen_if
    import sobel_pkg::*;
#(
    parameter int unsigned PIX_W = DEF_PIX_W
) ();

    logic             in_valid;
    logic [PIX_W-1:0] in_pix;
    logic             in_ready;
    logic             out_valid;
    logic             out_sof;
    logic             out_eof;
    logic [PIX_W-1:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;

    // Pixel source / window sink side
    modport master (
        output in_valid, in_pix,
        input  in_ready, out_valid, out_sof, out_eof,
        input  p0, p1, p2, p3, p4, p5, p6, p7, p8
    );

    // Window generator side
    modport slave (
        input  in_valid, in_pix,
        output in_ready, out_valid, out_sof, out_eof,
        output p0, p1, p2, p3, p4, p5, p6, p7, p8
    );

endinterface

// File: rtl/sobel_line_buf.sv
// One-line pixel store with a single read-before-write port.
//   clk        : rising-edge clock
//   addr_i     : column address
//   wr_en_i    : write wdata_i at addr_i on the clock edge
//   wdata_i    : pixel to store
//   rdata_c_o  : combinational read of the old contents at addr_i
module sobel_line_buf #(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_c_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are never cleared; stale entries are masked downstream.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_c_o = mem_q[addr_i];

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: raster pixels in, one zero-padded window
// per pixel out, centred on that pixel, with a self-driven end-of-frame flush.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : sobel_window_gen_if.slave (pixel stream in, taps p0..p8 out)
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_W = DEF_IMG_W,
    parameter int unsigned IMG_H = DEF_IMG_H,
    parameter int unsigned PIX_W = DEF_PIX_W
) (
    input  logic              clk,
    input  logic              rst,
    sobel_window_gen_if.slave bus
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned FLC_W = $clog2(IMG_W + 1);

    state_e           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d, cc_q, cc_d;
    logic [ROW_W-1:0] row_q, row_d, cr_q, cr_d;
    logic [FLC_W-1:0] flc_q, flc_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, sof_q, eof_q;
    logic             advance_c, emit_c;
    logic             col_last_c, row_last_c, flush_done_c;
    logic             top_c, bot_c, lft_c, rgt_c;
    logic [PIX_W-1:0] new_pix_c, lb1_rd_c, lb2_rd_c;
    logic [PIX_W-1:0] col_c  [3];
    logic [PIX_W-1:0] win_q  [3][2];
    logic [PIX_W-1:0] tap_d  [9];
    logic [PIX_W-1:0] tap_q  [9];

    // Flush injects zeros in place of the (absent) next pixels.
    assign new_pix_c = (state_q == FLUSH) ? '0 : bus.in_pix;

    sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk       (clk),
        .addr_i    (col_q),
        .wr_en_i   (advance_c),
        .wdata_i   (new_pix_c),
        .rdata_c_o (lb1_rd_c)
    );

    sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb2 (
        .clk       (clk),
        .addr_i    (col_q),
        .wr_en_i   (advance_c),
        .wdata_i   (lb1_rd_c),
        .rdata_c_o (lb2_rd_c)
    );

    // Incoming right column: two lines ago, one line ago, newest.
    assign col_c[0] = lb2_rd_c;
    assign col_c[1] = lb1_rd_c;
    assign col_c[2] = new_pix_c;

    assign col_last_c   = (col_q == COL_W'(IMG_W - 1));
    assign row_last_c   = (row_q == ROW_W'(IMG_H - 1));
    assign flush_done_c = (flc_q == FLC_W'(IMG_W));

    // Border flags of the window centre being emitted this cycle.
    assign top_c = (cr_q == '0);
    assign bot_c = (cr_q == ROW_W'(IMG_H - 1));
    assign lft_c = (cc_q == '0);
    assign rgt_c = (cc_q == COL_W'(IMG_W - 1));

    // Control: next state, advance/emit strobes, counters.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        cc_d      = cc_q;
        cr_d      = cr_q;
        flc_d     = flc_q;
        advance_c = 1'b0;
        emit_c    = 1'b0;

        case (state_q)
            FILL: begin
                if (bus.in_valid) begin
                    advance_c = 1'b1;
                    // Pixel k == IMG_W completes the first window.
                    if (row_q == ROW_W'(1) && col_q == '0) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.in_valid) begin
                    advance_c = 1'b1;
                    emit_c    = 1'b1;
                    if (row_last_c && col_last_c) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                advance_c = 1'b1;
                emit_c    = 1'b1;
                if (flush_done_c) begin
                    state_d = FILL;
                end else begin
                    flc_d = flc_q + FLC_W'(1);
                end
            end
            default: state_d = FILL;
        endcase

        // Newest-pixel coordinates also address the line buffers.
        if (advance_c) begin
            col_d = col_last_c ? '0 : col_q + COL_W'(1);
            if (col_last_c) begin
                row_d = row_last_c ? '0 : row_q + ROW_W'(1);
            end
        end

        if (emit_c) begin
            cc_d = rgt_c ? '0 : cc_q + COL_W'(1);
            if (rgt_c) begin
                cr_d = bot_c ? '0 : cr_q + ROW_W'(1);
            end
        end

        if (state_q == FLUSH && flush_done_c) begin
            col_d = '0;
            row_d = '0;
            cc_d  = '0;
            cr_d  = '0;
            flc_d = '0;
        end

        in_ready_d = (state_d != FLUSH);
    end

    // Masked taps of the window formed by this advance.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if ((r == 0 && top_c) || (r == 2 && bot_c) ||
                    (c == 0 && lft_c) || (c == 2 && rgt_c)) begin
                    tap_d[r*3+c] = '0;
                end else if (c == 2) begin
                    tap_d[r*3+c] = col_c[r];
                end else begin
                    tap_d[r*3+c] = win_q[r][c];
                end
            end
        end
    end

    // State, counters, window columns and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            col_q       <= '0;
            row_q       <= '0;
            cc_q        <= '0;
            cr_q        <= '0;
            flc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                tap_q[i] <= '0;
            end
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= '0;
                win_q[r][1] <= '0;
            end
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cc_q        <= cc_d;
            cr_q        <= cr_d;
            flc_q       <= flc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= emit_c;
            sof_q       <= emit_c && top_c && lft_c;
            eof_q       <= emit_c && bot_c && rgt_c;
            if (emit_c) begin
                for (int i = 0; i < 9; i++) begin
                    tap_q[i] <= tap_d[i];
                end
            end
            // Only the two newest columns are kept; the third arrives live.
            if (advance_c) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= col_c[r];
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sof   = sof_q;
    assign bus.out_eof   = eof_q;
    assign bus.p0        = tap_q[0];
    assign bus.p1        = tap_q[1];
    assign bus.p2        = tap_q[2];
    assign bus.p3        = tap_q[3];
    assign bus.p4        = tap_q[4];
    assign bus.p5        = tap_q[5];
    assign bus.p6        = tap_q[6];
    assign bus.p7        = tap_q[7];
    assign bus.p8        = tap_q[8];

endmodule
